matmul_ctrl: RTL and testbench

MATMUL_CTRL -- requirements
Module: matmul_ctrl

---
 rtl/matmul_pkg.sv | 26 ++
 rtl/matmul_ctrl_mac.sv | 29 ++
 rtl/matmul_ctrl.sv | 152 +++++++++++++++
 tb/tb_matmul_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared sizing, FSM encoding and address helper for the matrix-multiply controller.
package matmul_pkg;

    localparam int N      = 8;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 19;
    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Row-major linear address: major * stride + minor.
    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [ADDR_W-1:0] major,
        input logic [ADDR_W-1:0] minor,
        input logic [ADDR_W-1:0] stride
    );
        return major * stride + minor;
    endfunction

endpackage

// File: rtl/matmul_ctrl_mac.sv
// Signed multiply-accumulate: clears on macc_clear, otherwise adds inA*inB each cycle.
module MAC #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                     clk,
    input  logic                     macc_clear,
    input  logic signed [DATA_W-1:0] inA,
    input  logic signed [DATA_W-1:0] inB,
    output logic signed [ACC_W-1:0]  macc_out
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod = inA * inB;

    // Size cast of a signed product sign-extends into the accumulator width.
    always_ff @(posedge clk) begin
        if (macc_clear) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

    assign macc_out = acc_q;

endmodule

// File: rtl/matmul_ctrl.sv
// Sequences C = A x B one element at a time through a single MAC, reading A/B from
// one-cycle-latency memories and writing each C element once, in row-major order.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int N      = matmul_pkg::N,
    parameter int DATA_W = matmul_pkg::DATA_W,
    parameter int ACC_W  = matmul_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        a_addr,
    input  logic signed [DATA_W-1:0] a_data,
    output logic [ADDR_W-1:0]        b_addr,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     c_we,
    output logic [ADDR_W-1:0]        c_addr,
    output logic signed [ACC_W-1:0]  c_data
);

    localparam int                CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  PENULT = CNT_W'(N - 2);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(N);

    state_e            state_q;
    logic [CNT_W-1:0]  row_q, col_q, k_q;
    logic              busy_q, done_q, c_we_q;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q, c_addr_q;

    logic [CNT_W-1:0]  row_d, col_d;
    logic [ADDR_W-1:0] row_a, col_a, k_fetch;
    logic              row_last, col_last;

    logic                     macc_clear;
    logic signed [DATA_W-1:0] mac_a, mac_b;
    logic signed [ACC_W-1:0]  macc_out;

    assign row_a    = ADDR_W'(row_q);
    assign col_a    = ADDR_W'(col_q);
    assign row_last = (row_q == LAST);
    assign col_last = (col_q == LAST);

    always_comb begin
        row_d   = row_q;
        col_d   = col_q + CNT_W'(1);
        k_fetch = ADDR_W'(LAST);
        if (col_last) begin
            row_d = row_q + CNT_W'(1);
            col_d = '0;
        end
        // Addresses run one k ahead of the data; they stop at the last k.
        if (k_q < PENULT) begin
            k_fetch = ADDR_W'(k_q) + ADDR_W'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_we_q   <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= S_CLEAR;
                        busy_q   <= 1'b1;
                        row_q    <= '0;
                        col_q    <= '0;
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                    end
                end
                S_CLEAR: begin
                    state_q  <= S_RUN;
                    k_q      <= '0;
                    a_addr_q <= elem_addr(row_a, ADDR_W'(1), STRIDE);
                    b_addr_q <= elem_addr(ADDR_W'(1), col_a, STRIDE);
                end
                S_RUN: begin
                    a_addr_q <= elem_addr(row_a, k_fetch, STRIDE);
                    b_addr_q <= elem_addr(k_fetch, col_a, STRIDE);
                    if (k_q == LAST) begin
                        state_q  <= S_WRITE;
                        c_we_q   <= 1'b1;
                        c_addr_q <= elem_addr(row_a, col_a, STRIDE);
                    end else begin
                        k_q <= k_q + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    c_we_q <= 1'b0;
                    if (row_last && col_last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= S_CLEAR;
                        row_q    <= row_d;
                        col_q    <= col_d;
                        a_addr_q <= elem_addr(ADDR_W'(row_d), '0, STRIDE);
                        b_addr_q <= ADDR_W'(col_d);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // MAC inputs are zero outside RUN so the accumulator holds through WRITE.
    assign macc_clear = reset | (state_q == S_CLEAR);
    assign mac_a      = (state_q == S_RUN) ? a_data : '0;
    assign mac_b      = (state_q == S_RUN) ? b_data : '0;

    MAC #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk        (clk),
        .macc_clear (macc_clear),
        .inA        (mac_a),
        .inB        (mac_b),
        .macc_out   (macc_out)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign c_we   = c_we_q;
    assign a_addr = a_addr_q;
    assign b_addr = b_addr_q;
    assign c_addr = c_addr_q;
    assign c_data = macc_out;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: fixed-pattern jobs, restart/reset behaviour, one line per check.
module tb_matmul_ctrl;

    logic              clk = 1'b0;
    logic              reset, start;
    logic              busy, done, c_we;
    logic [5:0]        a_addr, b_addr, c_addr;
    logic signed [7:0] a_data, b_data;
    logic signed [18:0] c_data;

    logic signed [7:0]  amem [64];
    logic signed [7:0]  bmem [64];
    logic signed [18:0] cmem [64];
    bit                 written [64];

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt, dup_cnt, done_cnt, done_cyc, first_we;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        a_data <= amem[a_addr];
        b_data <= bmem[b_addr];
    end

    matmul_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .a_addr (a_addr),
        .a_data (a_data),
        .b_addr (b_addr),
        .b_data (b_data),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_data (c_data)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
        $display("check %-18s observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint expected_c(input int mode, input int r, input int c);
        case (mode)
            1:       return longint'(r * 8 + c);
            2:       return 64'sd131072;
            3:       return -8 * longint'(r + 1);
            default: return 64'sd8;
        endcase
    endfunction

    task automatic load(input int mode);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (mode)
                    1: begin amem[r*8+c] = (r == c) ? 8'sd1 : 8'sd0; bmem[r*8+c] = 8'(r*8+c); end
                    2: begin amem[r*8+c] = -8'sd128; bmem[r*8+c] = -8'sd128; end
                    3: begin amem[r*8+c] = 8'(r+1); bmem[r*8+c] = -8'sd1; end
                    default: begin amem[r*8+c] = 8'sd1; bmem[r*8+c] = 8'sd1; end
                endcase
            end
        end
    endtask

    // Starts a job and watches it for stop_at cycles (cycle 1 = first cycle after start is sampled).
    task automatic run_job(input int stop_at, input bit pulse_extra, input bit chk_addr);
        wr_cnt = 0; dup_cnt = 0; done_cnt = 0; done_cyc = -1; first_we = -1;
        for (int i = 0; i < 64; i++) begin
            written[i] = 1'b0;
            cmem[i] = '0;
        end
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= stop_at; cyc++) begin
            @(negedge clk);
            start = pulse_extra && (cyc == 50 || cyc == 641);
            if (c_we) begin
                if (written[c_addr]) dup_cnt++;
                written[c_addr] = 1'b1;
                cmem[c_addr] = c_data;
                wr_cnt++;
                if (first_we < 0) first_we = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_in_done", busy, 0);
            end
            if (pulse_extra && cyc == 643) chk("restart_ignored", busy, 0);
            if (chk_addr) begin
                case (cyc)
                    1:   begin chk("clr0_a", a_addr, 0);  chk("clr0_b", b_addr, 0);  chk("clr0_busy", busy, 1); end
                    2:   begin chk("run0_a", a_addr, 1);  chk("run0_b", b_addr, 8);  end
                    9:   begin chk("run7_a", a_addr, 7);  chk("run7_b", b_addr, 56); end
                    11:  begin chk("clr1_a", a_addr, 0);  chk("clr1_b", b_addr, 1);  end
                    91:  begin chk("clr9_a", a_addr, 8);  chk("clr9_b", b_addr, 1);  end
                    100: begin chk("wr9_we", c_we, 1);    chk("wr9_addr", c_addr, 9); end
                    default: ;
                endcase
            end
        end
        start = 1'b0;
    endtask

    task automatic check_job(input int mode);
        chk("done_cycle", done_cyc, 641);
        chk("done_pulses", done_cnt, 1);
        chk("write_count", wr_cnt, 64);
        chk("dup_writes", dup_cnt, 0);
        chk("first_write_cyc", first_we, 10);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                chk($sformatf("m%0d_c[%0d][%0d]", mode, r, c), cmem[r*8+c], expected_c(mode, r, c));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_we"}, c_we, 0);
        chk({tag, "_a_addr"}, a_addr, 0);
        chk({tag, "_b_addr"}, b_addr, 0);
        chk({tag, "_c_addr"}, c_addr, 0);
        chk({tag, "_c_data"}, c_data, 0);
    endtask

    initial begin
        int stray;
        reset = 1'b1;
        start = 1'b0;
        load(4);
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        load(1);
        run_job(650, 1'b1, 1'b1);
        check_job(1);

        load(2);
        run_job(650, 1'b0, 1'b0);
        check_job(2);

        load(3);
        run_job(650, 1'b0, 1'b0);
        check_job(3);

        // Abandon a job with reset asserted in cycle 300.
        load(1);
        run_job(300, 1'b0, 1'b0);
        chk("pre_rst_writes", wr_cnt, 30);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c_we || busy) stray++;
        end
        chk("post_rst_quiet", stray, 0);

        load(4);
        run_job(650, 1'b0, 1'b0);
        check_job(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
